// File: rtl/instr_mem_fetch_if.sv
// Fetch and program-port bundle for instr_mem_fetch.
// The slave modport is the memory side and the master modport is the requester side.
interface instr_mem_fetch_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic [1:0]      resp_fault;
  logic            prog_we;
  logic            prog_ready;
  logic [31:0]     prog_addr;
  logic [XLEN-1:0] prog_wdata;
  logic            prog_err;

  modport slave (
    input  req_valid, req_addr, resp_ready, prog_we, prog_addr, prog_wdata,
    output req_ready, resp_valid, resp_data, resp_fault, prog_ready, prog_err
  );

  modport master (
    output req_valid, req_addr, resp_ready, prog_we, prog_addr, prog_wdata,
    input  req_ready, resp_valid, resp_data, resp_fault, prog_ready, prog_err
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// Clocked RV32I instruction memory: 1-cycle fetch with fault reporting, a run-time
// program-write port, and a post-reset sweep that fills the array with NOP.
module instr_mem_fetch #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 64,
  parameter logic [XLEN-1:0] NOP_WORD   = 32'h0000_0013,
  parameter int              INIT_SWEEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  instr_mem_fetch_if.slave   bus,
  output logic               init_done
);
  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [31:0]      DEPTH_W  = 32'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  // Misaligned wins over out of range; bits above the index only feed the range check.
  function automatic logic [1:0] addr_fault(input logic [31:0] addr);
    if (addr[1:0] != 2'b00) begin
      return 2'b01;
    end else if ({2'b00, addr[31:2]} >= DEPTH_W) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  logic [XLEN-1:0]  mem [DEPTH];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]  resp_data_q, resp_data_d;
  logic [1:0]       resp_fault_q, resp_fault_d;
  logic             prog_err_q, prog_err_d;

  logic             req_ready_s;
  logic             accept_s;
  logic [1:0]       fetch_fault_s;
  logic [1:0]       prog_fault_s;
  logic [XLEN-1:0]  rd_word_s;
  logic             mem_we_s;
  logic [IDX_W-1:0] mem_idx_s;
  logic [XLEN-1:0]  mem_wdata_s;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    resp_fault_d  = resp_fault_q;
    prog_err_d    = 1'b0;
    mem_we_s      = 1'b0;
    mem_idx_s     = cnt_q;
    mem_wdata_s   = NOP_WORD;

    req_ready_s   = (state_q == ST_RUN) && (!resp_valid_q || bus.resp_ready);
    accept_s      = bus.req_valid && req_ready_s;
    fetch_fault_s = addr_fault(bus.req_addr);
    prog_fault_s  = addr_fault(bus.prog_addr);
    rd_word_s     = mem[bus.req_addr[IDX_W+1:2]];

    case (state_q)
      ST_INIT: begin
        if (INIT_SWEEP != 0) begin
          mem_we_s = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.prog_we) begin
          if (prog_fault_s == 2'b00) begin
            mem_we_s    = 1'b1;
            mem_idx_s   = bus.prog_addr[IDX_W+1:2];
            mem_wdata_s = bus.prog_wdata;
          end else begin
            prog_err_d = 1'b1;
          end
        end else begin
          prog_err_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    // The array is read before the same-edge write lands, giving read-before-write.
    if (accept_s) begin
      resp_valid_d = 1'b1;
      resp_fault_d = fetch_fault_s;
      resp_data_d  = (fetch_fault_s == 2'b00) ? rd_word_s : NOP_WORD;
    end else if (resp_valid_q && bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end else begin
      resp_valid_d = resp_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= NOP_WORD;
      resp_fault_q <= 2'b00;
      prog_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
      prog_err_q   <= prog_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_idx_s] <= mem_wdata_s;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.prog_ready = (state_q == ST_RUN);
  assign bus.prog_err   = prog_err_q;
  assign init_done      = (state_q == ST_RUN);
endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: one sweeping instance (DEPTH 64) and one
// instance built without the sweep to show contents surviving reset.
module tb_instr_mem_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  logic rst1;
  logic init_done0;
  logic init_done1;
  int   checks;
  int   errors;

  instr_mem_fetch_if #(.XLEN(32)) bus0 ();
  instr_mem_fetch_if #(.XLEN(32)) bus1 ();

  instr_mem_fetch #(.XLEN(32), .DEPTH(64), .NOP_WORD(32'h0000_0013), .INIT_SWEEP(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .init_done(init_done0)
  );

  instr_mem_fetch #(.XLEN(32), .DEPTH(64), .NOP_WORD(32'h0000_0013), .INIT_SWEEP(0)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .init_done(init_done1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch0(input logic [31:0] a, output logic v, output logic [31:0] d,
                        output logic [1:0] f);
    bus0.req_addr   = a;
    bus0.req_valid  = 1'b1;
    bus0.resp_ready = 1'b1;
    tick();
    bus0.req_valid  = 1'b0;
    v = bus0.resp_valid;
    d = bus0.resp_data;
    f = bus0.resp_fault;
    tick();
  endtask

  task automatic write0(input logic [31:0] a, input logic [31:0] wd, output logic err);
    bus0.prog_addr  = a;
    bus0.prog_wdata = wd;
    bus0.prog_we    = 1'b1;
    tick();
    bus0.prog_we    = 1'b0;
    err = bus0.prog_err;
  endtask

  task automatic test_reset();
    int   n;
    logic seen_err;
    logic seen_rdy;
    tick();
    tick();
    checks++;
    if ({bus0.req_ready, bus0.resp_valid, bus0.prog_ready, bus0.prog_err, init_done0} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 00000",
               {bus0.req_ready, bus0.resp_valid, bus0.prog_ready, bus0.prog_err, init_done0});
    end
    checks++;
    if ({bus0.resp_data, bus0.resp_fault} !== {NOP, 2'b00}) begin
      errors++;
      $display("FAIL reset_resp got %h/%b expected %h/00", bus0.resp_data, bus0.resp_fault, NOP);
    end
    bus0.prog_we   = 1'b1;
    bus0.prog_addr = 32'h0000_0101;
    rst      = 1'b0;
    n        = 0;
    seen_err = 1'b0;
    seen_rdy = 1'b0;
    while (!init_done0 && n < 200) begin
      tick();
      n++;
      if (bus0.prog_err) seen_err = 1'b1;
      if (!init_done0 && (bus0.req_ready || bus0.prog_ready)) seen_rdy = 1'b1;
      if (n == 60) bus0.prog_we = 1'b0;
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL sweep_len got %0d expected 64", n);
    end
    checks++;
    if (seen_err !== 1'b0) begin
      errors++;
      $display("FAIL sweep_prog_err got %b expected 0", seen_err);
    end
    checks++;
    if (seen_rdy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_ready got %b expected 0", seen_rdy);
    end
    checks++;
    if ({bus0.req_ready, bus0.prog_ready} !== 2'b11) begin
      errors++;
      $display("FAIL run_ready got %b expected 11", {bus0.req_ready, bus0.prog_ready});
    end
  endtask

  task automatic test_sweep_fetch();
    logic [31:0] addrs [3];
    logic        v;
    logic [31:0] d;
    logic [1:0]  f;
    addrs[0] = 32'h0000_0000;
    addrs[1] = 32'h0000_007C;
    addrs[2] = 32'h0000_00FC;
    for (int i = 0; i < 3; i++) begin
      fetch0(addrs[i], v, d, f);
      checks++;
      if ({v, d, f} !== {1'b1, NOP, 2'b00}) begin
        errors++;
        $display("FAIL sweep_fetch@%h got v=%b d=%h f=%b expected v=1 d=%h f=00", addrs[i], v, d, f, NOP);
      end
    end
  endtask

  task automatic test_program();
    logic e0;
    logic e1;
    write0(32'h0000_0000, 32'h0041_82B3, e0);
    write0(32'h0000_0004, 32'h4094_03B3, e1);
    checks++;
    if ({e0, e1} !== 2'b00) begin
      errors++;
      $display("FAIL prog_ok_err got %b expected 00", {e0, e1});
    end
    bus0.resp_ready = 1'b1;
    bus0.req_addr   = 32'h0000_0000;
    bus0.req_valid  = 1'b1;
    tick();
    checks++;
    if ({bus0.resp_valid, bus0.resp_data, bus0.req_ready} !== {1'b1, 32'h0041_82B3, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first got v=%b d=%h rdy=%b expected v=1 d=004182b3 rdy=1",
               bus0.resp_valid, bus0.resp_data, bus0.req_ready);
    end
    bus0.req_addr = 32'h0000_0004;
    tick();
    bus0.req_valid = 1'b0;
    checks++;
    if ({bus0.resp_valid, bus0.resp_data, bus0.resp_fault} !== {1'b1, 32'h4094_03B3, 2'b00}) begin
      errors++;
      $display("FAIL b2b_second got v=%b d=%h f=%b expected v=1 d=409403b3 f=00",
               bus0.resp_valid, bus0.resp_data, bus0.resp_fault);
    end
    tick();
    checks++;
    if (bus0.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got %b expected 0", bus0.resp_valid);
    end
  endtask

  task automatic test_faults();
    logic        v;
    logic [31:0] d;
    logic [1:0]  f;
    logic        e;
    fetch0(32'h0000_0002, v, d, f);
    checks++;
    if ({v, d, f} !== {1'b1, NOP, 2'b01}) begin
      errors++;
      $display("FAIL misaligned got v=%b d=%h f=%b expected v=1 d=%h f=01", v, d, f, NOP);
    end
    fetch0(32'h0000_0100, v, d, f);
    checks++;
    if ({v, d, f} !== {1'b1, NOP, 2'b10}) begin
      errors++;
      $display("FAIL out_of_range got v=%b d=%h f=%b expected v=1 d=%h f=10", v, d, f, NOP);
    end
    fetch0(32'h0000_0102, v, d, f);
    checks++;
    if (f !== 2'b01) begin
      errors++;
      $display("FAIL fault_priority got %b expected 01", f);
    end
    write0(32'h0000_0101, 32'hFFFF_FFFF, e);
    checks++;
    if (e !== 1'b1) begin
      errors++;
      $display("FAIL prog_err_pulse got %b expected 1", e);
    end
    tick();
    checks++;
    if (bus0.prog_err !== 1'b0) begin
      errors++;
      $display("FAIL prog_err_clear got %b expected 0", bus0.prog_err);
    end
    fetch0(32'h0000_0000, v, d, f);
    checks++;
    if (d !== 32'h0041_82B3) begin
      errors++;
      $display("FAIL bad_write_nowrite got %h expected 004182b3", d);
    end
  endtask

  task automatic test_backpressure();
    bus0.resp_ready = 1'b0;
    bus0.req_addr   = 32'h0000_0004;
    bus0.req_valid  = 1'b1;
    tick();
    bus0.req_addr = 32'h0000_0000;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus0.resp_valid, bus0.resp_data, bus0.req_ready} !== {1'b1, 32'h4094_03B3, 1'b0}) begin
        errors++;
        $display("FAIL hold_%0d got v=%b d=%h rdy=%b expected v=1 d=409403b3 rdy=0",
                 i, bus0.resp_valid, bus0.resp_data, bus0.req_ready);
      end
      tick();
    end
    bus0.resp_ready = 1'b1;
    #1;
    checks++;
    if (bus0.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got %b expected 1", bus0.req_ready);
    end
    tick();
    bus0.req_valid = 1'b0;
    checks++;
    if ({bus0.resp_valid, bus0.resp_data} !== {1'b1, 32'h0041_82B3}) begin
      errors++;
      $display("FAIL release_next got v=%b d=%h expected v=1 d=004182b3", bus0.resp_valid, bus0.resp_data);
    end
    tick();
  endtask

  task automatic test_collision();
    logic        v;
    logic [31:0] d;
    logic [1:0]  f;
    bus0.resp_ready = 1'b1;
    bus0.req_addr   = 32'h0000_0008;
    bus0.req_valid  = 1'b1;
    bus0.prog_addr  = 32'h0000_0008;
    bus0.prog_wdata = 32'hDEAD_BEEF;
    bus0.prog_we    = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    bus0.prog_we   = 1'b0;
    checks++;
    if ({bus0.resp_valid, bus0.resp_data} !== {1'b1, NOP}) begin
      errors++;
      $display("FAIL collide_old got v=%b d=%h expected v=1 d=%h", bus0.resp_valid, bus0.resp_data, NOP);
    end
    tick();
    fetch0(32'h0000_0008, v, d, f);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL collide_new got %h expected deadbeef", d);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bus0.resp_ready = 1'b0;
    bus0.req_addr   = 32'h0000_0004;
    bus0.req_valid  = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    checks++;
    if (bus0.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid got %b expected 1", bus0.resp_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus0.resp_valid, bus0.resp_data, init_done0, bus0.req_ready} !== {1'b0, NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_drop got v=%b d=%h done=%b rdy=%b expected v=0 d=%h done=0 rdy=0",
               bus0.resp_valid, bus0.resp_data, init_done0, bus0.req_ready, NOP);
    end
    bus0.resp_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (init_done0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_done got %b expected 0", init_done0);
    end
    tick();
    rst = 1'b0;
    n   = 0;
    while (!init_done0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL resweep_len got %0d expected 64", n);
    end
  endtask

  task automatic test_no_sweep();
    rst1 = 1'b0;
    tick();
    checks++;
    if ({init_done1, bus1.req_ready, bus1.prog_ready} !== 3'b111) begin
      errors++;
      $display("FAIL nosweep_run got %b expected 111", {init_done1, bus1.req_ready, bus1.prog_ready});
    end
    bus1.prog_addr  = 32'h0000_0010;
    bus1.prog_wdata = 32'h1234_5678;
    bus1.prog_we    = 1'b1;
    tick();
    bus1.prog_we = 1'b0;
    rst1 = 1'b1;
    #1;
    checks++;
    if ({init_done1, bus1.prog_ready} !== 2'b00) begin
      errors++;
      $display("FAIL nosweep_reset got %b expected 00", {init_done1, bus1.prog_ready});
    end
    tick();
    rst1 = 1'b0;
    tick();
    bus1.req_addr  = 32'h0000_0010;
    bus1.req_valid = 1'b1;
    tick();
    bus1.req_valid = 1'b0;
    checks++;
    if ({bus1.resp_valid, bus1.resp_data, bus1.resp_fault} !== {1'b1, 32'h1234_5678, 2'b00}) begin
      errors++;
      $display("FAIL nosweep_keep got v=%b d=%h f=%b expected v=1 d=12345678 f=00",
               bus1.resp_valid, bus1.resp_data, bus1.resp_fault);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk  = 1'b0;
    rst  = 1'b1;
    rst1 = 1'b1;
    bus0.req_valid  = 1'b0;
    bus0.req_addr   = 32'h0;
    bus0.resp_ready = 1'b0;
    bus0.prog_we    = 1'b0;
    bus0.prog_addr  = 32'h0;
    bus0.prog_wdata = 32'h0;
    bus1.req_valid  = 1'b0;
    bus1.req_addr   = 32'h0;
    bus1.resp_ready = 1'b1;
    bus1.prog_we    = 1'b0;
    bus1.prog_addr  = 32'h0;
    bus1.prog_wdata = 32'h0;
    test_reset();
    test_sweep_fetch();
    test_program();
    test_faults();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_no_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
